// File: rtl/brot_pkg.sv
// Shared types for the pipelined barrel rotator: mode encoding and direction constants.
package brot_pkg;

    typedef enum logic [1:0] {
        ROT  = 2'b00,
        LSH  = 2'b01,
        ASH  = 2'b10,
        ROT2 = 2'b11
    } brot_mode_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/brot_stage.sv
// One combinational barrel stage: conditionally moves the word by SHIFT positions
// as a rotate, logical shift or arithmetic shift (fill supplies the sign bit).
import brot_pkg::*;

module brot_stage #(
    parameter int WIDTH = 8,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             en,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    // Ones in the SHIFT most-significant positions: the bits vacated by a right shift.
    localparam logic [WIDTH-1:0] FILL_MASK = ~({WIDTH{1'b1}} >> SHIFT);

    brot_mode_t mode_e;
    assign mode_e = brot_mode_t'(mode);

    always_comb begin
        result = data;
        if (en) begin
            if (dir == DIR_RIGHT) begin
                case (mode_e)
                    LSH:     result = data >> SHIFT;
                    ASH:     result = (data >> SHIFT) | (fill ? FILL_MASK : '0);
                    default: result = (data >> SHIFT) | (data << (WIDTH - SHIFT));
                endcase
            end else begin
                case (mode_e)
                    LSH, ASH: result = data << SHIFT;
                    default:  result = (data << SHIFT) | (data >> (WIDTH - SHIFT));
                endcase
            end
        end
    end

endmodule

// File: rtl/barrel_rot_pipe.sv
// Pipelined barrel rotator/shifter with a global-advance valid/ready handshake.
// Optional BROT_STATS_EN adds stat_count, a saturating count of output transfers.
import brot_pkg::*;

module barrel_rot_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef BROT_STATS_EN
    ,
    output logic [15:0]      stat_count
`endif
);

    logic [WIDTH-1:0] data_p [SHW];
    logic [SHW-1:0]   amt_p  [SHW];
    logic             dir_p  [SHW];
    logic [1:0]       mode_p [SHW];
    logic             msb_p  [SHW];
    logic             vld_p  [SHW];

    logic [WIDTH-1:0] src_data [SHW];
    logic [SHW-1:0]   src_amt  [SHW];
    logic             src_dir  [SHW];
    logic [1:0]       src_mode [SHW];
    logic             src_msb  [SHW];
    logic             src_vld  [SHW];
    logic [WIDTH-1:0] stage_res [SHW];

    logic adv;

    assign out_valid = vld_p[SHW-1];
    assign out_data  = data_p[SHW-1];
    // Whole pipe moves together; a stalled output freezes every stage, bubbles included.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign src_data[k] = in_data;
            assign src_amt[k]  = in_amt;
            assign src_dir[k]  = in_dir;
            assign src_mode[k] = in_mode;
            assign src_msb[k]  = in_data[WIDTH-1];
            assign src_vld[k]  = in_valid & in_ready;
        end else begin : g_body
            assign src_data[k] = data_p[k-1];
            assign src_amt[k]  = amt_p[k-1];
            assign src_dir[k]  = dir_p[k-1];
            assign src_mode[k] = mode_p[k-1];
            assign src_msb[k]  = msb_p[k-1];
            assign src_vld[k]  = vld_p[k-1];
        end

        brot_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k)
        ) u_stage (
            .data   (src_data[k]),
            .en     (src_amt[k][k]),
            .dir    (src_dir[k]),
            .mode   (src_mode[k]),
            .fill   (src_msb[k]),
            .result (stage_res[k])
        );
    end

    // Stage k register holds the word after moves by 2^0..2^k have been applied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SHW; k++) begin
                data_p[k] <= '0;
                amt_p[k]  <= '0;
                dir_p[k]  <= 1'b0;
                mode_p[k] <= '0;
                msb_p[k]  <= 1'b0;
                vld_p[k]  <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < SHW; k++) begin
                data_p[k] <= stage_res[k];
                amt_p[k]  <= src_amt[k];
                dir_p[k]  <= src_dir[k];
                mode_p[k] <= src_mode[k];
                msb_p[k]  <= src_msb[k];
                vld_p[k]  <= src_vld[k];
            end
        end
    end

    // Control carried by the last stage has no consumer downstream.
    logic unused_tail;
    assign unused_tail = ^{amt_p[SHW-1], dir_p[SHW-1], mode_p[SHW-1], msb_p[SHW-1]};

`ifdef BROT_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_count <= '0;
        end else if (out_valid && out_ready && stat_count != 16'hFFFF) begin
            stat_count <= stat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_barrel_rot_pipe.sv
// Self-checking bench for barrel_rot_pipe (WIDTH=8): directed vectors plus a scoreboard model.
`timescale 1ns/1ps
module tb_barrel_rot_pipe;

    localparam int W = 8;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [S-1:0] in_amt = '0;
    logic         in_dir = 1'b0;
    logic [1:0]   in_mode = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
`ifdef BROT_STATS_EN
    logic [15:0]  stat_count;
    logic [15:0]  stat_model = '0;
`endif

    barrel_rot_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_dir    (in_dir),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef BROT_STATS_EN
        ,
        .stat_count(stat_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_out = 0;

    typedef struct { logic [W-1:0] d; int c; } exp_t;
    exp_t exp_q[$];
    int   lat_q[$];
    int   ocyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each result bit is picked straight from the source word by index.
    function automatic logic [W-1:0] model(input logic [W-1:0] x, input int r,
                                           input logic dir, input logic [1:0] mode);
        logic [W-1:0] y;
        int src;
        bit rot;
        rot = (mode == 2'b00) || (mode == 2'b11);
        for (int i = 0; i < W; i++) begin
            src = dir ? i + r : i - r;
            if (src >= 0 && src < W) y[i] = x[src];
            else if (rot)            y[i] = x[(src + W) % W];
            else if (dir && mode == 2'b10) y[i] = x[W-1];
            else                     y[i] = 1'b0;
        end
        return y;
    endfunction

    // Compare process: scoreboard, handshake rule, stall stability.
    initial begin
        logic         hold;
        logic [W-1:0] held;
        exp_t         e;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                hold = 1'b0;
`ifdef BROT_STATS_EN
                stat_model = '0;
`endif
            end else begin
                chk("in_ready_rule", in_ready, !out_valid || out_ready);
                if (hold) begin
                    chk("stall_valid", out_valid, 1'b1);
                    chk("stall_data", out_data, held);
                end
`ifdef BROT_STATS_EN
                chk("stat_track", stat_count, stat_model);
                if (out_valid && out_ready && stat_model != 16'hFFFF) stat_model = stat_model + 16'd1;
`endif
                if (in_valid && in_ready) begin
                    e.d = model(in_data, int'(in_amt), in_dir, in_mode);
                    e.c = cyc;
                    exp_q.push_back(e);
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", out_data, 32'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        chk("stream_data", out_data, e.d);
                        lat_q.push_back(cyc - e.c);
                        ocyc_q.push_back(cyc);
                    end
                end
                hold = out_valid && !out_ready;
                held = out_data;
            end
        end
    end

    // Present a word and return just after the edge that accepts it (valid stays high).
    task automatic xfer(input logic [W-1:0] d, input int a, input logic dir, input logic [1:0] m);
        int n;
        in_data = d; in_amt = S'(a); in_dir = dir; in_mode = m; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= bound) chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic directed(input string name, input logic [W-1:0] d, input int a,
                            input logic dir, input logic [1:0] m, input logic [W-1:0] exp);
        int n;
        out_ready = 1'b1;
        xfer(d, a, dir, m);
        in_valid = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        chk({name, "_latency"}, n, S);
        chk(name, out_data, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [W-1:0] first;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_data", out_data, 8'h00);
        chk("reset_in_ready", in_ready, 1'b1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        directed("rot_right", 8'h96, 3, 1'b1, 2'b00, 8'hD2);
        directed("rot_left", 8'h96, 3, 1'b0, 2'b00, 8'hB4);
        directed("ash_right", 8'h96, 2, 1'b1, 2'b10, 8'hE5);
        directed("lsh_right", 8'h96, 2, 1'b1, 2'b01, 8'h25);
        directed("lsh_left", 8'h96, 2, 1'b0, 2'b01, 8'h58);
        directed("ash_left", 8'h96, 2, 1'b0, 2'b10, 8'h58);
        directed("rot_alias", 8'h96, 3, 1'b1, 2'b11, 8'hD2);
        directed("amt_zero", 8'h96, 0, 1'b1, 2'b10, 8'h96);
        directed("ash_pos", 8'h6A, 7, 1'b1, 2'b10, 8'h00);
        directed("ash_neg7", 8'h80, 7, 1'b1, 2'b10, 8'hFF);

        // Streaming: 8 back-to-back words with out_ready held high.
        lat_q.delete(); ocyc_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) xfer(8'h11 * i[7:0] + 8'h03, i, i[0], i[2:1]);
        in_valid = 1'b0;
        drain(20);
        chk("stream_count", lat_q.size(), 8);
        if (lat_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("stream_latency", lat_q[i], S);
                chk("stream_consecutive", ocyc_q[i] - ocyc_q[0], i);
            end
        end

        // Backpressure: fill the pipe, stall 5 cycles, then release.
        base = n_out;
        out_ready = 1'b0;
        xfer(8'h96, 1, 1'b1, 2'b10);
        xfer(8'h5A, 2, 1'b0, 2'b00);
        xfer(8'hC3, 5, 1'b1, 2'b01);
        in_data = 8'h3C; in_amt = 3'd6; in_dir = 1'b0; in_mode = 2'b00;
        first = 8'hCB;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_data", out_data, first);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        xfer(8'h3C, 6, 1'b0, 2'b00);
        xfer(8'hF0, 4, 1'b1, 2'b10);
        xfer(8'h01, 7, 1'b0, 2'b01);
        in_valid = 1'b0;
        drain(20);
        chk("bp_no_loss", n_out - base, 6);

        // Random fields with random consumer backpressure.
        base = n_out;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 30; i++)
                    xfer(8'($urandom), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                         2'($urandom_range(0, 3)));
                in_valid = 1'b0;
            end
        join
        out_ready = 1'b1;
        drain(30);
        chk("rand_no_loss", n_out - base, 30);

        // Reset with 3 words in flight: none may ever appear.
        base = n_out;
        out_ready = 1'b0;
        xfer(8'hAA, 1, 1'b1, 2'b00);
        xfer(8'hBB, 2, 1'b1, 2'b00);
        xfer(8'hCC, 3, 1'b1, 2'b00);
        in_valid = 1'b0;
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_out_data", out_data, 8'h00);
        chk("rst_mid_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("rst_discard", n_out - base, 0);

`ifdef BROT_STATS_EN
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) xfer(8'(i), 1, 1'b0, 2'b00);
        in_valid = 1'b0;
        drain(20);
        chk("stat_ten", stat_count, 16'd10);
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        force dut.stat_count = 16'hFFFD;
        stat_model = 16'hFFFD;
        @(posedge clk);
        #1;
        release dut.stat_count;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) xfer(8'(i), 2, 1'b1, 2'b01);
        in_valid = 1'b0;
        drain(20);
        chk("stat_saturate", stat_count, 16'hFFFF);
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
